mem_stage: RTL

Memory-access stage of the five-stage MIPS pipeline, directly downstream of the execute stage. It holds the EX/MEM pipeline register and issues LW/SW accesses to the data bus through a req/ack handshake. It stalls the upstream pipeline while an access is outstanding and aborts on misalignment or timeout. It produces the registered MEM/WB writeback triple.

---
 rtl/mem_stage_pkg.sv | 27 ++
 rtl/mem_stage_ex_mem_reg.sv | 24 ++
 rtl/mem_stage.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings and the EX/MEM stage-register payload for the MIPS memory stage.
package mem_stage_pkg;

    localparam logic [2:0]  MEM_NOP_OP = 3'b000;
    localparam logic [2:0]  MEM_LW_OP  = 3'b001;
    localparam logic [2:0]  MEM_SW_OP  = 3'b010;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        we;
    } ex_mem_t;

    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == MEM_LW_OP) || (op == MEM_SW_OP);
    endfunction

endpackage

// File: rtl/mem_stage_ex_mem_reg.sv
// EX/MEM pipeline register: loads on enable, clears to a NOP with we = 0 on reset.
module ex_mem_reg
    import mem_stage_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    en,
    input  ex_mem_t d,
    output ex_mem_t q
);

    ex_mem_t stage_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else if (en) begin
            stage_q <= d;
        end
    end

    assign q = stage_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM register, LW/SW bus access with req/ack, timeout and
// misalignment abort, and the registered MEM/WB writeback triple.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic [4:0]  wb_write_reg,
    input  logic [31:0] wb_write_data,
    input  logic        wb_we,
    output logic        stall_out,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic [4:0]  wb_reg_o,
    output logic [31:0] wb_data_o,
    output logic        wb_we_o,
    output logic        mem_err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    ex_mem_t     stage_in;
    ex_mem_t     stage_q;
    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  wb_reg_q, wb_reg_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_we_q, wb_we_d;
    logic        mem_err_q, mem_err_d;
    logic        access, misalign, timeout, stage_en;

    assign stage_in = '{op: mem_op, addr: mem_addr, data: mem_data,
                        rd: wb_write_reg, wdata: wb_write_data, we: wb_we};

    ex_mem_reg u_ex_mem_reg (
        .clk (clk),
        .rst (rst),
        .en  (stage_en),
        .d   (stage_in),
        .q   (stage_q)
    );

    // Timeout releases the stall in its own cycle so the next instruction loads on the abort edge.
    assign access    = (state_q == ACCESS);
    assign misalign  = is_mem_op(stage_q.op) && (stage_q.addr[1:0] != 2'b00);
    assign timeout   = access && !dbus_ack && (cnt_q == CNT_LAST);
    assign stall_out = access && !dbus_ack && !timeout;
    assign stage_en  = !stall_out;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wb_reg_d  = wb_reg_q;
        wb_data_d = wb_data_q;
        wb_we_d   = wb_we_q;
        mem_err_d = 1'b0;

        if (!access) begin
            wb_reg_d  = stage_q.rd;
            wb_data_d = stage_q.wdata;
            wb_we_d   = stage_q.we && !misalign;
            mem_err_d = misalign;
        end else if (dbus_ack) begin
            wb_reg_d = stage_q.rd;
            if (stage_q.op == MEM_LW_OP) begin
                wb_data_d = dbus_rdata;
                wb_we_d   = stage_q.we;
            end else begin
                wb_data_d = ZeroWord;
                wb_we_d   = 1'b0;
            end
        end else if (timeout) begin
            wb_reg_d  = stage_q.rd;
            wb_data_d = ZeroWord;
            wb_we_d   = 1'b0;
            mem_err_d = 1'b1;
        end else begin
            wb_we_d = 1'b0;
            cnt_d   = cnt_q + 8'd1;
        end

        if (stage_en) begin
            state_d = (is_mem_op(mem_op) && (mem_addr[1:0] == 2'b00)) ? ACCESS : IDLE;
            cnt_d   = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            wb_reg_q  <= 5'd0;
            wb_data_q <= ZeroWord;
            wb_we_q   <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wb_reg_q  <= wb_reg_d;
            wb_data_q <= wb_data_d;
            wb_we_q   <= wb_we_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign dbus_req   = access;
    assign dbus_we    = access && (stage_q.op == MEM_SW_OP);
    assign dbus_addr  = access ? {stage_q.addr[31:2], 2'b00} : ZeroWord;
    assign dbus_wdata = access ? stage_q.data : ZeroWord;
    assign wb_reg_o   = wb_reg_q;
    assign wb_data_o  = wb_data_q;
    assign wb_we_o    = wb_we_q;
    assign mem_err    = mem_err_q;

endmodule
